// File: rtl/core_hazard_ctrl_pkg.sv
// Shared core definitions: hazard classes from the control decoder and
// the hazard controller state encoding.
package core_hazard_ctrl_pkg;

    localparam logic [1:0] HZRD_OTHER = 2'd0;
    localparam logic [1:0] HZRD_BRNCH = 2'd1;
    localparam logic [1:0] HZRD_JUMP  = 2'd2;
    localparam logic [1:0] HZRD_LOAD  = 2'd3;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR      = 2'd2;

    // x0 never carries a dependency, so it is excluded from the match.
    function automatic logic src_match(input logic [4:0] rd,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/core_hazard_ctrl_sat_cnt.sv
// 16-bit up-counter with enable that sticks at all-ones instead of wrapping.
module core_sat_cnt
    import core_hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] count
);

    // Count enabled cycles, holding at the maximum value.
    always_ff @(posedge clk) begin
        if (rst)
            count <= 16'd0;
        else if (en && (count != 16'hFFFF))
            count <= count + 16'd1;
    end

endmodule

// File: rtl/core_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with timeout, branch/jump
// redirect flushes and load-use interlock, plus a stall-cycle perf counter.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | normal flow; redirect and load-use are serviced here
// ST_MEM_WAIT | L1D request outstanding; whole pipe held, wait_cnt running
// ST_ERR      | L1D timed out; pipe held and error flagged until reset
module core_hazard_ctrl
    import core_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_val,
    input  logic [1:0]  dec_haz_cmd,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        exe_redirect,
    input  logic        mem_l1d_val,
    input  logic        l1d_ack,
    output logic        stall_pc,
    output logic        stall_dec,
    output logic        stall_exe,
    output logic        stall_mem,
    output logic        bubble_exe,
    output logic        flush_dec,
    output logic        hzrd_error_out,
    output logic [15:0] perf_stall_cnt_out
);

    localparam logic [7:0] TMAX = 8'(TIMEOUT_MAX);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic       exe_load_q;
    logic [4:0] exe_rd_q;
    logic       err_q;

    logic mem_stall;
    logic redirect;
    logic load_use;

    // Hazard resolution with priority memory stall > redirect > load-use.
    // A redirect or load-use in the ack cycle of MEM_WAIT is serviced, since
    // execute is released in that same cycle.
    always_comb begin
        mem_stall = 1'b0;
        redirect  = 1'b0;
        load_use  = 1'b0;
        if (!rst) begin
            case (state)
                ST_RUN:      mem_stall = mem_l1d_val && !l1d_ack;
                ST_MEM_WAIT: mem_stall = !l1d_ack;
                default:     mem_stall = 1'b1;
            endcase
            redirect = !mem_stall && exe_redirect;
            load_use = !mem_stall && !exe_redirect && dec_val && exe_load_q &&
                       src_match(exe_rd_q, dec_rs1, dec_rs2);
        end
    end

    assign stall_pc       = mem_stall || load_use;
    assign stall_dec      = mem_stall || load_use;
    assign stall_exe      = mem_stall;
    assign stall_mem      = mem_stall;
    assign bubble_exe     = redirect || load_use;
    assign flush_dec      = redirect;
    // Masked during reset so every output reads 0 while rst is high.
    assign hzrd_error_out = err_q && !rst;

    // Memory-wait FSM with timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    wait_cnt <= 8'd0;
                    if (mem_l1d_val && !l1d_ack)
                        state <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (l1d_ack) begin
                        state    <= ST_RUN;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == TMAX) begin
                        state <= ST_ERR;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_ERR;
                    err_q <= 1'b1;
                end
            endcase
        end
    end

    // Track whether the instruction entering execute is a load, and its rd.
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_load_q <= 1'b0;
            exe_rd_q   <= 5'd0;
        end else if (mem_stall) begin
            exe_load_q <= exe_load_q;
            exe_rd_q   <= exe_rd_q;
        end else if (bubble_exe) begin
            exe_load_q <= 1'b0;
            exe_rd_q   <= 5'd0;
        end else begin
            exe_load_q <= dec_val && (dec_haz_cmd == HZRD_LOAD);
            exe_rd_q   <= dec_rd;
        end
    end

    core_sat_cnt u_perf_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_pc),
        .count (perf_stall_cnt_out)
    );

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Directed bench for core_hazard_ctrl with TIMEOUT_MAX=4. Each cycle's
// expected output vector is queued when stimulus is applied and popped
// when the outputs are sampled on the falling edge.
module tb_core_hazard_ctrl;

    localparam logic [1:0] C_OTHER = 2'd0;
    localparam logic [1:0] C_LOAD  = 2'd3;

    // {stall_pc, stall_dec, stall_exe, stall_mem, bubble_exe, flush_dec, err}
    localparam logic [6:0] E_IDLE = 7'b0000000;
    localparam logic [6:0] E_MEM  = 7'b1111000;
    localparam logic [6:0] E_LU   = 7'b1100100;
    localparam logic [6:0] E_RD   = 7'b0000110;
    localparam logic [6:0] E_ERR  = 7'b1111001;

    typedef struct {
        string      tag;
        logic [6:0] vec;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_val;
    logic [1:0]  dec_haz_cmd;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        exe_redirect, mem_l1d_val, l1d_ack;
    logic        stall_pc, stall_dec, stall_exe, stall_mem;
    logic        bubble_exe, flush_dec, hzrd_error_out;
    logic [15:0] perf_stall_cnt_out;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    core_hazard_ctrl #(.TIMEOUT_MAX(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .dec_val            (dec_val),
        .dec_haz_cmd        (dec_haz_cmd),
        .dec_rs1            (dec_rs1),
        .dec_rs2            (dec_rs2),
        .dec_rd             (dec_rd),
        .exe_redirect       (exe_redirect),
        .mem_l1d_val        (mem_l1d_val),
        .l1d_ack            (l1d_ack),
        .stall_pc           (stall_pc),
        .stall_dec          (stall_dec),
        .stall_exe          (stall_exe),
        .stall_mem          (stall_mem),
        .bubble_exe         (bubble_exe),
        .flush_dec          (flush_dec),
        .hzrd_error_out     (hzrd_error_out),
        .perf_stall_cnt_out (perf_stall_cnt_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: apply inputs after the rising edge, queue the expected
    // outputs, then pop and compare on the falling edge.
    task automatic cyc(input string tag, input logic r, input logic dv,
                       input logic [1:0] cmd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic redir, input logic mv, input logic ack,
                       input logic [6:0] expv);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; dec_val = dv; dec_haz_cmd = cmd;
        dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
        exe_redirect = redir; mem_l1d_val = mv; l1d_ack = ack;
        e.tag = tag;
        e.vec = expv;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk(e.tag, {25'd0, stall_pc, stall_dec, stall_exe, stall_mem,
                        bubble_exe, flush_dec, hzrd_error_out}, {25'd0, e.vec});
        end
    endtask

    task automatic idle(input string tag, input logic [6:0] expv);
        cyc(tag, 1'b0, 1'b0, C_OTHER, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, expv);
    endtask

    initial begin
        rst = 1'b1; dec_val = 1'b0; dec_haz_cmd = C_OTHER;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
        exe_redirect = 1'b0; mem_l1d_val = 1'b0; l1d_ack = 1'b0;

        // Reset: outputs forced low even with hazard inputs active.
        cyc("rst_a", 1'b1, 1'b0, C_OTHER, 0, 0, 0, 1'b1, 1'b1, 1'b0, E_IDLE);
        cyc("rst_b", 1'b1, 1'b1, C_LOAD, 1, 1, 1, 1'b0, 1'b1, 1'b0, E_IDLE);
        idle("post_rst", E_IDLE);
        chk("perf_reset", {16'd0, perf_stall_cnt_out}, 32'd0);

        // Load-use through rs1: LW x5 ; ADD x6, x5, x1.
        cyc("lw_x5", 1'b0, 1'b1, C_LOAD, 0, 0, 5, 1'b0, 1'b0, 1'b0, E_IDLE);
        cyc("lu_rs1", 1'b0, 1'b1, C_OTHER, 5, 1, 6, 1'b0, 1'b0, 1'b0, E_LU);
        cyc("lu_rs1_go", 1'b0, 1'b1, C_OTHER, 5, 1, 6, 1'b0, 1'b0, 1'b0, E_IDLE);
        chk("perf_lu1", {16'd0, perf_stall_cnt_out}, 32'd1);

        // Load into x0 never interlocks.
        cyc("lw_x0", 1'b0, 1'b1, C_LOAD, 0, 0, 0, 1'b0, 1'b0, 1'b0, E_IDLE);
        cyc("x0_user", 1'b0, 1'b1, C_OTHER, 0, 0, 8, 1'b0, 1'b0, 1'b0, E_IDLE);

        // Load-use through rs2.
        cyc("lw_x7", 1'b0, 1'b1, C_LOAD, 0, 0, 7, 1'b0, 1'b0, 1'b0, E_IDLE);
        cyc("lu_rs2", 1'b0, 1'b1, C_OTHER, 2, 7, 9, 1'b0, 1'b0, 1'b0, E_LU);
        cyc("lu_rs2_go", 1'b0, 1'b1, C_OTHER, 2, 7, 9, 1'b0, 1'b0, 1'b0, E_IDLE);
        chk("perf_lu2", {16'd0, perf_stall_cnt_out}, 32'd2);

        // Same-cycle ack: no stall.
        cyc("ack_same", 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b1, 1'b1, E_IDLE);
        idle("ack_same_after", E_IDLE);

        // Memory wait: ack three cycles after the request.
        cyc("mw_req", 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b1, 1'b0, E_MEM);
        cyc("mw_w1", 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b1, 1'b0, E_MEM);
        cyc("mw_w2", 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b1, 1'b0, E_MEM);
        cyc("mw_ack", 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b1, 1'b1, E_IDLE);
        // Back in RUN: a fresh request with ack does not stall.
        cyc("mw_run", 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b1, 1'b1, E_IDLE);
        chk("perf_mw", {16'd0, perf_stall_cnt_out}, 32'd5);

        // Redirect wins over load-use.
        cyc("lw_x9", 1'b0, 1'b1, C_LOAD, 0, 0, 9, 1'b0, 1'b0, 1'b0, E_IDLE);
        cyc("redir_lu", 1'b0, 1'b1, C_OTHER, 9, 0, 4, 1'b1, 1'b0, 1'b0, E_RD);
        cyc("redir_after", 1'b0, 1'b1, C_OTHER, 9, 0, 4, 1'b0, 1'b0, 1'b0, E_IDLE);
        chk("perf_redir", {16'd0, perf_stall_cnt_out}, 32'd5);

        // Redirect suppressed while memory-stalled, serviced on release.
        cyc("rw_req", 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b1, 1'b0, E_MEM);
        cyc("rw_redir", 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b1, 1'b1, 1'b0, E_MEM);
        cyc("rw_ack", 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b1, 1'b1, 1'b1, E_RD);
        idle("rw_after", E_IDLE);

        // Load-use held behind a memory stall, then re-presented.
        cyc("lw_x3", 1'b0, 1'b1, C_LOAD, 0, 0, 3, 1'b0, 1'b0, 1'b0, E_IDLE);
        cyc("lum_req", 1'b0, 1'b1, C_OTHER, 3, 0, 4, 1'b0, 1'b1, 1'b0, E_MEM);
        cyc("lum_ack", 1'b0, 1'b1, C_OTHER, 3, 0, 4, 1'b0, 1'b1, 1'b1, E_LU);
        cyc("lum_go", 1'b0, 1'b1, C_OTHER, 3, 0, 4, 1'b0, 1'b0, 1'b0, E_IDLE);
        chk("perf_lum", {16'd0, perf_stall_cnt_out}, 32'd9);

        // Reset abandons a memory wait.
        cyc("rm_req", 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b1, 1'b0, E_MEM);
        cyc("rm_w1", 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b1, 1'b0, E_MEM);
        cyc("rm_rst", 1'b1, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b1, 1'b0, E_IDLE);
        idle("rm_after", E_IDLE);
        chk("perf_rm", {16'd0, perf_stall_cnt_out}, 32'd0);

        // Timeout: request cycle, then wait_cnt 0..4 in MEM_WAIT, then ERR.
        cyc("to_req", 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b1, 1'b0, E_MEM);
        for (int i = 0; i < 5; i++)
            cyc($sformatf("to_w%0d", i), 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b1, 1'b0, E_MEM);
        cyc("to_err", 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b1, 1'b0, E_ERR);
        cyc("to_err_ack", 1'b0, 1'b1, C_OTHER, 0, 0, 0, 1'b1, 1'b1, 1'b1, E_ERR);
        chk("perf_to", {16'd0, perf_stall_cnt_out}, 32'd7);
        cyc("to_err_hold", 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b0, 1'b0, E_ERR);

        // One-cycle reset clears the error and all stalls.
        cyc("err_rst", 1'b1, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b0, 1'b0, E_IDLE);
        idle("err_after", E_IDLE);
        cyc("err_run", 1'b0, 1'b0, C_OTHER, 0, 0, 0, 1'b0, 1'b1, 1'b1, E_IDLE);
        chk("perf_err_rst", {16'd0, perf_stall_cnt_out}, 32'd0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
